// File: rtl/priority_selector_pkg.sv
// Shared constants and helpers for the fixed-priority selector and its encoder.
// Source 0 always has the highest priority.
package priority_selector_pkg;

    localparam int unsigned NUM_INPUTS_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned MAX_INPUTS     = 32;

    // Index of the lowest set bit; 0 for an all-zero vector (callers qualify with 'any').
    function automatic int unsigned lsb_index(input logic [MAX_INPUTS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_INPUTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage : priority_selector_pkg

// File: rtl/priority_selector_if.sv
// Request/data/grant bundle between contending sources and the selector.
// The master side drives requests and data; the slave side returns the registered grant.
interface priority_selector_if
    import priority_selector_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned IDX_W     = $clog2(NUM_INPUTS)
);

    logic [NUM_INPUTS-1:0] req;
    logic [DATA_WIDTH-1:0] data_in [NUM_INPUTS-1:0];
    logic [DATA_WIDTH-1:0] data_out;
    logic [IDX_W-1:0]      grant;
    logic                  valid;

    modport master (
        output req,
        output data_in,
        input  data_out,
        input  grant,
        input  valid
    );

    modport slave (
        input  req,
        input  data_in,
        output data_out,
        output grant,
        output valid
    );

endinterface : priority_selector_if

// File: rtl/priority_selector_encoder.sv
// Combinational lowest-index-wins priority encoder, reusable by other arbiters.
// The index never exceeds NUM_INPUTS-1 because request bits beyond NUM_INPUTS are tied to zero.
module prio_encoder
    import priority_selector_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
    localparam int unsigned IDX_W     = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    logic [MAX_INPUTS-1:0] req_ext_s;

    // Widen to the helper's fixed width and resolve the winning index.
    always_comb begin
        req_ext_s = MAX_INPUTS'(req);
        idx       = IDX_W'(lsb_index(req_ext_s));
        any       = |req;
    end

endmodule : prio_encoder

// File: rtl/priority_selector.sv
// Fixed-priority N:1 selector: registers the winning source's data and index each cycle.
// Outputs clear to zero when nobody requests, so grant=0/valid=0 always means idle.
module priority_selector
    import priority_selector_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned IDX_W     = $clog2(NUM_INPUTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    priority_selector_if.slave  bus
);

    logic [IDX_W-1:0]      sel_s;
    logic                  any_s;

    logic [DATA_WIDTH-1:0] data_out_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [IDX_W-1:0]      grant_d;
    logic [IDX_W-1:0]      grant_q;
    logic                  valid_d;
    logic                  valid_q;

    prio_encoder #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_prio_encoder (
        .req (bus.req),
        .idx (sel_s),
        .any (any_s)
    );

    // Data mux and next-state values; idle cycles load zeros rather than holding.
    always_comb begin
        data_out_d = {DATA_WIDTH{1'b0}};
        grant_d    = {IDX_W{1'b0}};
        valid_d    = 1'b0;
        if (any_s) begin
            data_out_d = bus.data_in[sel_s];
            grant_d    = sel_s;
            valid_d    = 1'b1;
        end else begin
            data_out_d = {DATA_WIDTH{1'b0}};
            grant_d    = {IDX_W{1'b0}};
            valid_d    = 1'b0;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= {DATA_WIDTH{1'b0}};
            grant_q    <= {IDX_W{1'b0}};
            valid_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.grant    = grant_q;
    assign bus.valid    = valid_q;

endmodule : priority_selector

// File: tb/tb_priority_selector.sv
// Self-checking bench for priority_selector: directed table, multi-cycle corners,
// and randomized traffic on a 4-input and a 5-input (non power of two) instance.
module tb_priority_selector;

    logic clk;
    logic rst_n;

    priority_selector_if #(.NUM_INPUTS(4), .DATA_WIDTH(8)) bus4 ();
    priority_selector_if #(.NUM_INPUTS(5), .DATA_WIDTH(8)) bus5 ();

    priority_selector #(.NUM_INPUTS(4), .DATA_WIDTH(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    priority_selector #(.NUM_INPUTS(5), .DATA_WIDTH(8)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  exp_data;
        int          exp_grant;
        logic        exp_valid;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive4(input logic [3:0] r, input logic [31:0] d);
        bus4.req = r;
        for (int i = 0; i < 4; i++) bus4.data_in[i] = d[8*i +: 8];
    endtask

    task automatic drive5(input logic [4:0] r, input logic [39:0] d);
        bus5.req = r;
        for (int i = 0; i < 5; i++) bus5.data_in[i] = d[8*i +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: isolate the lowest set bit arithmetically, then take its log2.
    function automatic void ref_pick(input logic [31:0] r, output bit any, output int idx);
        logic [31:0] onehot;
        any    = (r != 32'd0);
        onehot = r & (~r + 32'd1);
        idx    = 0;
        while (onehot > 32'd1) begin
            onehot = onehot >> 1;
            idx++;
        end
    endfunction

    task automatic check4(input string tag, input logic [7:0] d, input int g, input logic v);
        check({tag, ".data"},  32'(bus4.data_out), 32'(d));
        check({tag, ".grant"}, 32'(bus4.grant),    32'(g));
        check({tag, ".valid"}, 32'(bus4.valid),    32'(v));
    endtask

    vec_t vecs [7];

    initial begin
        logic [31:0] base;
        logic [3:0]  r4;
        logic [4:0]  r5;
        logic [31:0] d4;
        logic [39:0] d5;
        bit          any;
        int          idx;

        base = {8'h44, 8'h33, 8'h22, 8'h11};
        vecs[0] = '{4'b0010, base, 8'h22, 1, 1'b1};
        vecs[1] = '{4'b1000, base, 8'h44, 3, 1'b1};
        vecs[2] = '{4'b0101, base, 8'h11, 0, 1'b1};
        vecs[3] = '{4'b1100, base, 8'h33, 2, 1'b1};
        vecs[4] = '{4'b1111, base, 8'h11, 0, 1'b1};
        vecs[5] = '{4'b0000, base, 8'h00, 0, 1'b0};
        vecs[6] = '{4'b0100, base, 8'h33, 2, 1'b1};

        // Reset with everyone requesting: outputs clear without a clock edge.
        rst_n = 1'b1;
        drive4(4'b1111, base);
        drive5(5'b11111, 40'h5544332211);
        #1 rst_n = 1'b0;
        #1;
        check4("reset_async", 8'h00, 0, 1'b0);
        tick();
        tick();
        check4("reset_held", 8'h00, 0, 1'b0);
        check("reset_held5.valid", 32'(bus5.valid), 32'd0);

        // Release with no requests: still idle.
        @(negedge clk);
        rst_n = 1'b1;
        drive4(4'b0000, base);
        drive5(5'b00000, 40'h0);
        tick();
        check4("idle_after_release", 8'h00, 0, 1'b0);

        // Directed priority table.
        for (int i = 0; i < 7; i++) begin
            drive4(vecs[i].req, vecs[i].data);
            tick();
            check4($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_grant, vecs[i].exp_valid);
        end

        // Data tracking while a request is held.
        drive4(4'b0010, base);
        tick();
        check4("track_before", 8'h22, 1, 1'b1);
        drive4(4'b0010, {8'h44, 8'h33, 8'h5A, 8'h11});
        tick();
        check4("track_after", 8'h5A, 1, 1'b1);

        // Asynchronous reset in the middle of a grant, then recovery.
        #2 rst_n = 1'b0;
        #1;
        check4("midgrant_reset", 8'h00, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check4("midgrant_recover", 8'h5A, 1, 1'b1);

        // Randomized traffic on both instances against the reference.
        for (int n = 0; n < 300; n++) begin
            r4 = 4'($urandom_range(0, 15));
            r5 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) r4 = 4'b0000;
            if ($urandom_range(0, 7) == 0) r5 = 5'b10000;
            d4 = $urandom;
            d5 = {8'($urandom), $urandom};
            drive4(r4, d4);
            drive5(r5, d5);
            tick();

            ref_pick(32'(r4), any, idx);
            check("rand4.data",  32'(bus4.data_out), any ? 32'(d4[8*idx +: 8]) : 32'd0);
            check("rand4.grant", 32'(bus4.grant),    any ? 32'(idx) : 32'd0);
            check("rand4.valid", 32'(bus4.valid),    32'(any));

            ref_pick(32'(r5), any, idx);
            check("rand5.data",  32'(bus5.data_out), any ? 32'(d5[8*idx +: 8]) : 32'd0);
            check("rand5.grant", 32'(bus5.grant),    any ? 32'(idx) : 32'd0);
            check("rand5.valid", 32'(bus5.valid),    32'(any));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_priority_selector

// File: doc/priority_selector.md
Name: priority_selector

Overview:
- Fixed-priority N:1 selector with registered outputs.
- Each cycle it picks the lowest-indexed active request. It registers that source's data word and index, and presents them one clock later.
- Sits in front of a shared resource (bus or write port) that several sources contend for.
- Index 0 has the highest priority; index NUM_INPUTS-1 has the lowest.

Parameters:
- NUM_INPUTS, 4, number of requesting sources; legal range 2..32.
- DATA_WIDTH, 8, width of each data word in bits; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_INPUTS  request vector; bit i set means source i is requesting.
- data_in  input  unpacked array [NUM_INPUTS-1:0] of DATA_WIDTH  per-source data word.
- data_out  output  DATA_WIDTH  data of the granted source, registered.
- grant  output  $clog2(NUM_INPUTS)  binary index of the granted source, registered.
- valid  output  1  high when data_out and grant reflect an active request.

Behaviour:
- Reset:
  - rst_n low clears data_out, grant and valid to 0 immediately (asynchronous).
  - Release is synchronous to the first clk rising edge after rst_n goes high.
- Selection (combinational):
  - sel = the index of the least-significant set bit of req.
  - any = OR-reduction of req.
- Registration, on each rising clk edge with rst_n high:
  - If any = 1: data_out <= data_in[sel], grant <= sel, valid <= 1.
  - If any = 0: data_out <= 0, grant <= 0, valid <= 0. Outputs are not held.
- Latency:
  - Exactly 1 cycle from the req/data_in sample edge to the outputs.
  - No handshake and no backpressure. A grant lasts exactly as long as the request is held.
- Priority examples (NUM_INPUTS = 4):
  - 4'b0101 → 0.
  - 4'b1100 → 2.
  - 4'b1111 → 0.
  - 4'b1000 → 3.
- Data tracking: data_in changes while a request is held appear at the next edge. There is no capture at grant time.
- Grant width:
  - grant is exactly $clog2(NUM_INPUTS) bits.
  - If NUM_INPUTS is not a power of two, grant never exceeds NUM_INPUTS-1.
- Unambiguous zero: grant = 0 together with valid = 0 means idle. grant = 0 together with valid = 1 means source 0 is granted.
- Reset mid-operation: outputs clear immediately. The first valid output appears one edge after release.
- No X-propagation: outputs are defined for every req value, including all-zeros and all-ones.
- Constructs: the selection is a parameterised loop or priority encoder, with no hard-coded case table. It is synthesisable as always_comb plus one always_ff with an asynchronous reset.

Decomposition:
- Shared package priority_selector_pkg:
  - Default NUM_INPUTS and DATA_WIDTH constants.
  - A helper function lsb_index(vector) returning the index of the lowest set bit.
- One sub-module, prio_encoder:
  - Parameterised by NUM_INPUTS.
  - Outputs the index and any from req.
  - Purely combinational, and reusable by other arbiters.
- Top-level contents: the data mux and the output registers.

Test Plan:
- Reset and idle: assert rst_n=0 with req=4'b1111, then release with req=4'b0000; all outputs read 0 (data_out=8'h00, grant=0, valid=0).
- Single request: data_in={8'h44,8'h33,8'h22,8'h11} (index 3..0). req=4'b0010 → next cycle data_out=8'h22, grant=1, valid=1. req=4'b1000 → data_out=8'h44, grant=3.
- Multiple requests: req=4'b0101 → data_out=8'h11, grant=0. req=4'b1100 → data_out=8'h33, grant=2.
- All requesting, then clear: req=4'b1111 → data_out=8'h11, grant=0, valid=1. Next req=4'b0000 → data_out=8'h00, grant=0, valid=0 after 1 cycle.
- Latency and tracking: change data_in[1] from 8'h22 to 8'h5A while req=4'b0010 is held → data_out reads 8'h5A exactly one edge later.
- Asynchronous reset mid-grant: while valid=1, pull rst_n low between edges → outputs clear immediately without waiting for a clock edge. After release, the first edge restores the selection.
